// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared widths, counts and well-known register indices for the register file
package register_file_pkg;
    localparam int REG_DATA_W = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

    // A write only lands when enabled and not aimed at the hardwired zero register.
    function automatic logic is_writable(input logic we, input logic [REG_ADDR_W-1:0] wa);
        return we && (wa != REG_ZERO);
    endfunction
endpackage

// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - write/read port bundle between decode logic (master) and the register file (slave)
interface register_file_if
    import register_file_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
);
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    modport master (output we, wa, wd, ra1, ra2, input rd1, rd2);
    modport slave  (input we, wa, wd, ra1, ra2, output rd1, rd2);
endinterface

// File: rtl/register_file_mux_32x1.sv
// rtl/register_file_mux_32x1.sv - 32-input combinational read mux used for each register file read port
module mux_32x1 #(
    parameter int W = 32
) (
    input  logic [4:0]   i_sel,
    input  logic [W-1:0] i_in [32],
    output logic [W-1:0] o_out
);
    assign o_out = i_in[i_sel];
endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - MIPS 32x32 register file, two async read ports, one sync write port, r0 hardwired to zero
// Optional write-through bypass on both read ports when REGFILE_BYPASS_EN is defined.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    register_file_if.slave bus
);
    localparam int N = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs   [N];
    logic [DATA_W-1:0] w_mux_in [N];
    logic              w_wr_en;
    logic [DATA_W-1:0] w_rd1_raw;
    logic [DATA_W-1:0] w_rd2_raw;

    assign w_wr_en = is_writable(bus.we, bus.wa);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[bus.wa] <= bus.wd;
        end
    end

    // Input 0 of each mux is tied to zero so r0 never depends on storage contents.
    always_comb begin
        w_mux_in    = r_regs;
        w_mux_in[0] = '0;
    end

    mux_32x1 #(.W(DATA_W)) u_rd1_mux (
        .i_sel (bus.ra1),
        .i_in  (w_mux_in),
        .o_out (w_rd1_raw)
    );

    mux_32x1 #(.W(DATA_W)) u_rd2_mux (
        .i_sel (bus.ra2),
        .i_in  (w_mux_in),
        .o_out (w_rd2_raw)
    );

`ifdef REGFILE_BYPASS_EN
    logic w_byp1;
    logic w_byp2;

    assign w_byp1  = rst_n && w_wr_en && (bus.ra1 == bus.wa);
    assign w_byp2  = rst_n && w_wr_en && (bus.ra2 == bus.wa);
    assign bus.rd1 = w_byp1 ? bus.wd : w_rd1_raw;
    assign bus.rd2 = w_byp2 ? bus.wd : w_rd2_raw;
`else
    assign bus.rd1 = w_rd1_raw;
    assign bus.rd2 = w_rd2_raw;
`endif
endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - self-checking bench for register_file against an array reference model
`timescale 1ns/1ps
module tb_register_file;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [31:0] model [32];

    register_file_if bus ();

    register_file dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_rd(input logic [4:0] ra);
        if (ra == 5'd0) return 32'h0;
        if (!rst_n) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (bus.we && bus.wa != 5'd0 && ra == bus.wa) return bus.wd;
`endif
        return model[ra];
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (bus.we && bus.wa != 5'd0) begin
            model[bus.wa] = bus.wd;
        end
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.we = 1'b1;
        bus.wa = a;
        bus.wd = d;
        @(posedge clk);
        model_edge();
        #1;
        bus.we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        bus.we = 1'b0; bus.wa = '0; bus.wd = '0; bus.ra1 = '0; bus.ra2 = '0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        #3;
        for (int i = 0; i < 32; i++) begin
            bus.ra1 = 5'(i); bus.ra2 = 5'(31 - i);
            #0.1;
            checks++;
            if (bus.rd1 !== 32'h0 || bus.rd2 !== 32'h0) begin
                failures++;
                $display("FAIL reset_init addr=%0d rd1=%h rd2=%h required=0", i, bus.rd1, bus.rd2);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'hFFFF_FFFF);
        // Pulse reset mid-cycle with a write pending; reads must go to 0 before the next edge.
        @(negedge clk);
        bus.we = 1'b1; bus.wa = 5'd9; bus.wd = 32'h1357_9BDF;
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        for (int i = 0; i < 32; i++) begin
            bus.ra1 = 5'(i); bus.ra2 = 5'(i ^ 5'h1F);
            #0.1;
            checks++;
            if (bus.rd1 !== 32'h0 || bus.rd2 !== 32'h0) begin
                failures++;
                $display("FAIL reset_async addr=%0d rd1=%h rd2=%h required=0", i, bus.rd1, bus.rd2);
            end
        end
        @(posedge clk);
        #1;
        bus.ra1 = 5'd9;
        #0.1;
        checks++;
        if (bus.rd1 !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_write rd1=%h required=0", bus.rd1);
        end
        @(negedge clk);
        bus.we = 1'b0;
        rst_n  = 1'b1;
        #1;
        checks++;
        if (bus.rd1 !== 32'h0) begin
            failures++;
            $display("FAIL reset_write_lost rd1=%h required=0", bus.rd1);
        end
    endtask

    task automatic test_basic();
        write_reg(5'd5, 32'hDEAD_BEEF);
        bus.ra1 = 5'd5; bus.ra2 = 5'd6;
        #1;
        checks++;
        if (bus.rd1 !== 32'hDEAD_BEEF || bus.rd2 !== 32'h0) begin
            failures++;
            $display("FAIL basic rd1=%h rd2=%h required=deadbeef/0", bus.rd1, bus.rd2);
        end
    endtask

    task automatic test_r0();
        write_reg(5'd0, 32'h1234_5678);
        bus.ra1 = 5'd0; bus.ra2 = 5'd0;
        #1;
        checks++;
        if (bus.rd1 !== 32'h0 || bus.rd2 !== 32'h0) begin
            failures++;
            $display("FAIL r0_write rd1=%h rd2=%h required=0", bus.rd1, bus.rd2);
        end
    endtask

    task automatic test_we_low();
        write_reg(5'd7, 32'hA5A5_A5A5);
        @(negedge clk);
        bus.we = 1'b0; bus.wa = 5'd7; bus.wd = 32'h0; bus.ra1 = 5'd7;
        @(posedge clk);
        model_edge();
        #1;
        checks++;
        if (bus.rd1 !== 32'hA5A5_A5A5) begin
            failures++;
            $display("FAIL we_low rd1=%h required=a5a5a5a5", bus.rd1);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] pre;
        write_reg(5'd3, 32'h1);
        @(negedge clk);
        bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 32'h2; bus.ra1 = 5'd3; bus.ra2 = 5'd3;
`ifdef REGFILE_BYPASS_EN
        pre = 32'h2;
`else
        pre = 32'h1;
`endif
        #1;
        checks++;
        if (bus.rd1 !== pre || bus.rd2 !== pre) begin
            failures++;
            $display("FAIL same_cycle_pre rd1=%h rd2=%h required=%h", bus.rd1, bus.rd2, pre);
        end
        @(posedge clk);
        model_edge();
        #0.1;
        checks++;
        if (bus.rd1 !== 32'h2 || bus.rd2 !== 32'h2) begin
            failures++;
            $display("FAIL same_cycle_post rd1=%h rd2=%h required=2", bus.rd1, bus.rd2);
        end
        bus.we = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        for (int i = 1; i < 32; i++) begin
            bus.we = 1'b1; bus.wa = 5'(i); bus.wd = 32'(i) * 32'h0101_0101;
            @(posedge clk);
            model_edge();
            @(negedge clk);
        end
        bus.we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.ra1 = 5'(i); bus.ra2 = 5'(31 - i);
            #0.2;
            checks++;
            if (bus.rd1 !== 32'(i) * 32'h0101_0101 || bus.rd2 !== 32'(31 - i) * 32'h0101_0101) begin
                failures++;
                $display("FAIL sweep pair=(%0d,%0d) rd1=%h rd2=%h required=%h/%h", i, 31 - i,
                         bus.rd1, bus.rd2, 32'(i) * 32'h0101_0101, 32'(31 - i) * 32'h0101_0101);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] e1, e2;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            bus.we  = ($urandom_range(0, 3) != 0);
            bus.wa  = 5'($urandom_range(0, 31));
            bus.wd  = $urandom;
            bus.ra1 = ($urandom_range(0, 3) == 0) ? bus.wa : 5'($urandom_range(0, 31));
            bus.ra2 = ($urandom_range(0, 3) == 0) ? bus.wa : 5'($urandom_range(0, 31));
            #1;
            e1 = exp_rd(bus.ra1);
            e2 = exp_rd(bus.ra2);
            checks++;
            if (bus.rd1 !== e1 || bus.rd2 !== e2) begin
                failures++;
                $display("FAIL random n=%0d ra1=%0d ra2=%0d rd1=%h rd2=%h required=%h/%h",
                         n, bus.ra1, bus.ra2, bus.rd1, bus.rd2, e1, e2);
            end
            @(posedge clk);
            model_edge();
        end
        @(negedge clk);
        bus.we = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_r0();
        test_we_low();
        test_same_cycle();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
